regfile_sb: RTL

8-entry × WIDTH register file with an integrated one-bit-per-register scoreboard, sitting in the decode stage of the pipeline. The write port is fed from writeback: the 3-bit write address is decoded, together with write enable, into eight one-hot register strobes. It provides two combinational read ports with same-cycle write bypass to the decode/issue logic. The scoreboard tracks registers with an in-flight producer and reports busy status to hazard/stall control.

---
 rtl/regfile_sb.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// 8-entry register file with write-through bypass on both read ports and a
// one-bit-per-register scoreboard that flags double producers and orphan writes.
module regfile_sb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             WrEn,
  input  logic [2:0]       WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [2:0]       Rd1Addr,
  input  logic [2:0]       Rd2Addr,
  output logic [WIDTH-1:0] Rd1Data,
  output logic [WIDTH-1:0] Rd2Data,
  input  logic             IssueEn,
  input  logic [2:0]       IssueAddr,
  output logic             Rd1Busy,
  output logic             Rd2Busy,
  output logic             Err
);

  localparam int NREGS = 8;

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] wr_strobe;
  logic [NREGS-1:0] issue_strobe;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             err_q;
  logic             double_issue;
  logic             orphan_write;
  logic             rd1_hit;
  logic             rd2_hit;

  // One-hot strobes from the write and issue addresses.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_strobe    = '0;
    issue_strobe = '0;
    if (WrEn)    wr_strobe[WrAddr]       = 1'b1;
    if (IssueEn) issue_strobe[IssueAddr] = 1'b1;
  end

  // NOTE: the storage array is reset because reads after reset must return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (wr_strobe[i]) regs[i] <= WrData;
    end
  end

  // Set wins over clear: a new producer replaces the one writing back now.
  always_comb begin
    busy_next    = (busy & ~wr_strobe) | issue_strobe;
    double_issue = |(issue_strobe & busy & ~wr_strobe);
    orphan_write = |(wr_strobe & ~busy & ~issue_strobe);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      err_q <= 1'b0;
    end else begin
      busy  <= busy_next;
      err_q <= err_q | double_issue | orphan_write;
    end
  end

  // Bypass and busy are masked during reset so nothing leaks from the inputs.
  always_comb begin
    rd1_hit = WrEn && (WrAddr == Rd1Addr);
    rd2_hit = WrEn && (WrAddr == Rd2Addr);
    Rd1Data = '0;
    Rd2Data = '0;
    Rd1Busy = 1'b0;
    Rd2Busy = 1'b0;
    if (rst_n) begin
      Rd1Data = rd1_hit ? WrData : regs[Rd1Addr];
      Rd2Data = rd2_hit ? WrData : regs[Rd2Addr];
      Rd1Busy = busy[Rd1Addr] & ~rd1_hit;
      Rd2Busy = busy[Rd2Addr] & ~rd2_hit;
    end
  end

  assign Err = err_q;

endmodule
